// File: rtl/seg_pkg.sv
// Shared types and default sizing for the character segmentation slice.
package seg_pkg;

   localparam int DEF_CW     = 7;
   localparam int DEF_MIN_W  = 2;
   localparam int DEF_MAX_W  = 24;
   localparam int DEF_QDEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      INK,
      DRAIN
   } seg_state_e;

   typedef struct packed {
      logic [DEF_CW-1:0] start;
      logic [DEF_CW-1:0] width;
      logic              split;
   } seg_desc_t;

endpackage

// File: rtl/char_seg_ctrl_if.sv
// Segment descriptor handshake between segmenter and recogniser.
interface char_seg_ctrl_if #(
   parameter int CW = seg_pkg::DEF_CW
);
   logic          seg_valid;
   logic          seg_ready;
   logic [CW-1:0] seg_start;
   logic [CW-1:0] seg_width;
   logic          seg_split;

   modport master (
      output seg_valid,
      output seg_start,
      output seg_width,
      output seg_split,
      input  seg_ready
   );

   modport slave (
      input  seg_valid,
      input  seg_start,
      input  seg_width,
      input  seg_split,
      output seg_ready
   );
endinterface

// File: rtl/seg_fifo.sv
// First-word-fall-through descriptor queue; caller only pushes when
// there is room (or a pop frees it) and only pops when non-empty.
module seg_fifo
   import seg_pkg::*;
#(
   parameter int QDEPTH = DEF_QDEPTH
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  seg_desc_t din,
   input  logic      pop,
   output seg_desc_t dout,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(QDEPTH);

   seg_desc_t     mem_q [QDEPTH];
   seg_desc_t     mem_d [QDEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
         rd_d = rd_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == (AW+1)'(QDEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/char_seg_ctrl.sv
// Column-scan segmenter: finds ink runs in a text line and queues
// (start, width) windows for the per-character recogniser.
module char_seg_ctrl
   import seg_pkg::*;
#(
   parameter int CW     = DEF_CW,
   parameter int MIN_W  = DEF_MIN_W,
   parameter int MAX_W  = DEF_MAX_W,
   parameter int QDEPTH = DEF_QDEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            line_start,
   input  logic            col_valid,
   input  logic            col_ink,
   input  logic            line_end,
   char_seg_ctrl_if.master seg,
   output logic [CW-1:0]   char_count,
   output logic            busy,
   output logic            overflow
);
   seg_state_e    state_q, state_d;
   logic [CW-1:0] col_cnt_q, col_cnt_d;
   logic [CW-1:0] start_q, start_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          busy_q;

   logic [CW-1:0] col_inc;
   logic [CW-1:0] close_w;
   logic [CW-1:0] run_w;
   logic          close;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   seg_desc_t     push_desc;
   seg_desc_t     head;
   logic          fifo_full;
   logic          fifo_empty;

   assign col_inc = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + CW'(1);
   assign close_w = col_cnt_q - start_q;
   // width the run reaches once the current ink column is counted
   assign run_w   = col_cnt_q - start_q + CW'(1);
   assign pop     = seg.seg_valid && seg.seg_ready;

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      start_d   = start_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      close     = 1'b0;
      push_req  = 1'b0;
      push_desc = '0;
      if (line_start) begin
         state_d   = GAP;
         col_cnt_d = '0;
         count_d   = '0;
         ovf_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            GAP: begin
               if (line_end) begin
                  state_d = DRAIN;
               end else if (col_valid) begin
                  col_cnt_d = col_inc;
                  if (col_ink) begin
                     start_d = col_cnt_q;
                     state_d = INK;
                  end
               end
            end
            INK: begin
               if (line_end) begin
                  close   = 1'b1;
                  state_d = DRAIN;
               end else if (col_valid) begin
                  col_cnt_d = col_inc;
                  if (!col_ink) begin
                     close   = 1'b1;
                     state_d = GAP;
                  end else if (run_w == CW'(MAX_W)) begin
                     push_req  = 1'b1;
                     push_desc = '{start: start_q,
                                   width: CW'(MAX_W),
                                   split: 1'b1};
                     state_d   = GAP;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (close && close_w >= CW'(MIN_W)) begin
            push_req  = 1'b1;
            push_desc = '{start: start_q,
                          width: close_w,
                          split: 1'b0};
         end
      end
      push_ok = push_req && (!fifo_full || pop);
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (push_ok && count_q != '1) count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         col_cnt_q <= '0;
         start_q   <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         start_q   <= start_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   seg_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .din   (push_desc),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign seg.seg_valid = !fifo_empty;
   assign seg.seg_start = head.start;
   assign seg.seg_width = head.width;
   assign seg.seg_split = head.split;
   assign char_count    = count_q;
   assign busy          = busy_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_char_seg_ctrl.sv
// Scoreboard bench for char_seg_ctrl.
module tb_char_seg_ctrl;
   import seg_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       line_start;
   logic       col_valid;
   logic       col_ink;
   logic       line_end;
   logic [6:0] char_count;
   logic       busy;
   logic       overflow;

   int checks   = 0;
   int failures = 0;
   seg_desc_t exp_q[$];

   char_seg_ctrl_if sif ();

   char_seg_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .col_valid  (col_valid),
      .col_ink    (col_ink),
      .line_end   (line_end),
      .seg        (sif),
      .char_count (char_count),
      .busy       (busy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic seg_desc_t d(input int s, input int w, input bit sp);
      return '{start: 7'(s), width: 7'(w), split: sp};
   endfunction

   always @(negedge clk) begin
      seg_desc_t e;
      if (!reset && sif.seg_valid && sif.seg_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_seg", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("seg", {17'b0, sif.seg_start, sif.seg_width, sif.seg_split},
                {17'b0, e});
         end
      end
   end

   task automatic col(input bit ink);
      col_valid = 1'b1;
      col_ink   = ink;
      @(posedge clk); #1;
      col_valid = 1'b0;
      col_ink   = 1'b0;
   endtask

   task automatic cols(input int n, input bit ink);
      repeat (n) col(ink);
   endtask

   task automatic start_line;
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
   endtask

   task automatic end_line;
      line_end = 1'b1;
      @(posedge clk); #1;
      line_end = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, {31'b0, busy}, 0);
      chk({tag, "_sb"}, exp_q.size(), 0);
   endtask

   initial begin
      reset         = 1'b1;
      line_start    = 1'b0;
      line_end      = 1'b0;
      col_valid     = 1'b0;
      col_ink       = 1'b0;
      sif.seg_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, sif.seg_valid}, 0);
      chk("rst_cnt", {25'b0, char_count}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_ovf", {31'b0, overflow}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: simple 3-wide glyph
      sif.seg_ready = 1'b1;
      start_line();
      chk("t1_busy", {31'b0, busy}, 1);
      cols(2, 1'b0);
      exp_q.push_back(d(2, 3, 0));
      cols(3, 1'b1);
      cols(5, 1'b0);
      chk("t1_cnt", {25'b0, char_count}, 1);
      end_line();
      wait_idle("t1_idle");
      chk("t1_cnt_end", {25'b0, char_count}, 1);

      // 2: single-column noise
      start_line();
      cols(5, 1'b0);
      col(1'b1);
      cols(3, 1'b0);
      chk("t2_valid", {31'b0, sif.seg_valid}, 0);
      chk("t2_cnt", {25'b0, char_count}, 0);
      end_line();
      wait_idle("t2_idle");

      // 3: force split at MAX_W
      start_line();
      exp_q.push_back(d(0, 24, 1));
      exp_q.push_back(d(24, 6, 0));
      cols(30, 1'b1);
      col(1'b0);
      chk("t3_cnt", {25'b0, char_count}, 2);
      end_line();
      wait_idle("t3_idle");

      // 4: overflow with stalled consumer
      sif.seg_ready = 1'b0;
      start_line();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(d(4 * i, 3, 0));
         cols(3, 1'b1);
         col(1'b0);
      end
      chk("t4_cnt", {25'b0, char_count}, 4);
      chk("t4_ovf", {31'b0, overflow}, 1);
      chk("t4_valid", {31'b0, sif.seg_valid}, 1);
      sif.seg_ready = 1'b1;
      wait_drain("t4_drain");
      @(posedge clk); #1;
      chk("t4_ovf_hold", {31'b0, overflow}, 1);
      end_line();
      wait_idle("t4_idle");
      chk("t4_ovf_idle", {31'b0, overflow}, 1);
      start_line();
      chk("t4_ovf_clr", {31'b0, overflow}, 0);
      chk("t4_cnt_clr", {25'b0, char_count}, 0);
      end_line();
      wait_idle("t4_idle2");

      // 5: line_end while in ink
      start_line();
      cols(37, 1'b0);
      exp_q.push_back(d(37, 3, 0));
      cols(3, 1'b1);
      end_line();
      chk("t5_state", 32'(dut.state_q), 32'(DRAIN));
      chk("t5_busy", {31'b0, busy}, 1);
      wait_idle("t5_idle");
      chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
      chk("t5_cnt", {25'b0, char_count}, 1);

      // 6a: async reset mid-ink with entries queued
      sif.seg_ready = 1'b0;
      start_line();
      exp_q.push_back(d(0, 3, 0));
      exp_q.push_back(d(4, 3, 0));
      cols(3, 1'b1);
      col(1'b0);
      cols(3, 1'b1);
      col(1'b0);
      cols(2, 1'b1);
      chk("t6_valid", {31'b0, sif.seg_valid}, 1);
      chk("t6_cnt", {25'b0, char_count}, 2);
      chk("t6_state", 32'(dut.state_q), 32'(INK));
      reset = 1'b1;
      #2;
      chk("t6r_valid", {31'b0, sif.seg_valid}, 0);
      chk("t6r_cnt", {25'b0, char_count}, 0);
      chk("t6r_busy", {31'b0, busy}, 0);
      chk("t6r_ovf", {31'b0, overflow}, 0);
      chk("t6r_head", {17'b0, sif.seg_start, sif.seg_width, sif.seg_split}, 0);
      chk("t6r_state", 32'(dut.state_q), 32'(IDLE));
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // 6b: line_start mid-line keeps queue, drops open run
      start_line();
      col(1'b0);
      exp_q.push_back(d(1, 3, 0));
      cols(3, 1'b1);
      col(1'b0);
      cols(2, 1'b1);
      start_line();
      chk("t6b_col", {25'b0, dut.col_cnt_q}, 0);
      chk("t6b_cnt", {25'b0, char_count}, 0);
      chk("t6b_valid", {31'b0, sif.seg_valid}, 1);
      chk("t6b_state", 32'(dut.state_q), 32'(GAP));
      col(1'b0);
      exp_q.push_back(d(1, 2, 0));
      cols(2, 1'b1);
      col(1'b0);
      chk("t6b_cnt2", {25'b0, char_count}, 1);
      sif.seg_ready = 1'b1;
      wait_drain("t6b_drain");

      // line_start beats line_end in the same cycle
      line_start = 1'b1;
      line_end   = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      line_end   = 1'b0;
      chk("both_state", 32'(dut.state_q), 32'(GAP));
      chk("both_busy", {31'b0, busy}, 1);
      end_line();
      wait_idle("both_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
